// File: rtl/dec_sop_sweep.sv
// dec_sop_sweep: registered N-to-2^N decoder evaluating a SOP function, with a hardware truth-table sweep
module dec_sop_sweep #(
  parameter int N = 4,
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit EN_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N-1:0]        sel,
  input  logic [(1<<N)-1:0]   minterm_mask,
  input  logic                sweep_start,
  output logic [(1<<N)-1:0]   dec_out,
  output logic                f_out,
  output logic                f_valid,
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [(1<<N)-1:0]   sweep_result
);
  localparam int M = 1 << N;
  localparam logic [N:0] LAST = (N+1)'(M - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_nx;
  logic [N:0] cnt;
  logic [M-1:0] shadow, onehot, lines;
  logic [N-1:0] code;
  logic act, f;
  always_comb begin
    act = en ^ EN_ACTIVE_LOW;
    code = (state == SWEEP) ? cnt[N-1:0] : sel;
    onehot = {{(M-1){1'b0}}, 1'b1} << code;
    lines = OUT_ACTIVE_LOW ? ~onehot : onehot;
    f = |(onehot & ((state == SWEEP) ? shadow : minterm_mask));
    state_nx = (state == IDLE) ? (sweep_start ? SWEEP : IDLE) :
               (state == SWEEP) ? ((act && cnt == LAST) ? DONE : SWEEP) : IDLE;
  end
  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      shadow <= '0;
      sweep_result <= '0;
      dec_out <= {M{OUT_ACTIVE_LOW}};
      f_out <= 1'b0;
      f_valid <= 1'b0;
    end else begin
      dec_out <= act ? lines : {M{OUT_ACTIVE_LOW}};
      f_out <= act & f;
      f_valid <= act;
      if (state == IDLE && sweep_start) begin
        cnt <= '0;
        shadow <= minterm_mask;
        sweep_result <= '0;
      end else if (state == SWEEP && act) begin
        cnt <= cnt + 1'b1;
        sweep_result[code] <= f;
      end
    end
  end
endmodule
